// File: rtl/seg7_scan_driver_pkg.sv
// ============================================================================
// Module   : seg7_scan_driver_pkg
// Purpose  : Shared definitions for the seven-segment display blocks. It holds
//            the hex-to-segment decode table and the scan FSM state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_scan_driver_pkg;

    // Scan FSM state encodings
    localparam logic [0:0] c_ST_ON    = 1'b0;
    localparam logic [0:0] c_ST_BLANK = 1'b1;

    // Active-high segment patterns {A,B,C,D,E,F,G}, with A = bit 6.
    // The packed array is listed from entry 15 (F) down to entry 0 (0).
    localparam logic [15:0][6:0] c_HEX_SEG = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
        7'h1F, 7'h77, 7'h73, 7'h7F,   // b A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

endpackage

`default_nettype wire

// File: rtl/seg7_hex_rom.sv
// ============================================================================
// Module   : seg7_hex_rom
// Purpose  : Combinational decode of one hex nibble to an active-high
//            seven-segment pattern.
// Ports    : i_nibble  in  4  hex digit value
//            o_seg     out 7  segments {A,B,C,D,E,F,G}, 1 = lit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_rom
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = c_HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed seven-segment driver for NUM_DIGITS hex digits.
//            It provides double-buffered frame-atomic updates, leading-zero
//            suppression, an anti-ghost blank between digits and selectable
//            output polarity.
// Ports    : HCLK         in   1            system clock
//            HRESET       in   1            asynchronous active-high reset
//            load         in   1            strobe: capture the display inputs
//            value_in     in   4*N          nibble i = hex digit i
//            dp_in        in   N            decimal point per digit, 1 = lit
//            digit_en_in  in   N            1 = digit displayed
//            lz_en        in   1            leading-zero suppression (live)
//            seg_o        out  7            segments {A..G}, A = bit 6
//            dp_o         out  1            decimal point segment
//            an_o         out  N            anode selects, one-hot or none
//            digit_idx    out  IDX_W        digit currently in its slot
//            frame_done   out  1            pulse on the last frame cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CLKS     = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    lz_en,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int MAX_CNT = (CLK_DIV > BLANK_CLKS) ? CLK_DIV : BLANK_CLKS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] c_ON_LAST    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'((BLANK_CLKS > 0) ? (BLANK_CLKS - 1) : 0);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that turn active-high internal values into pin polarity;
    // they are also the "everything off" pin values.
    localparam logic [6:0]            c_SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  c_DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    // Scan state
    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;

    // Display buffers
    logic [4*NUM_DIGITS-1:0] r_act_val, r_pend_val;
    logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_en, r_pend_en;
    logic                    r_pend_valid;

    // Output registers
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_fd;

    logic [0:0]            w_state_nx;
    logic [IDX_W-1:0]      w_idx_nx;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic                  w_adv;
    logic                  w_wrap;
    logic                  w_nx_is_wrap;
    logic [NUM_DIGITS-1:0] w_sup;
    logic                  w_zero_run;
    logic [3:0]            w_nib;
    logic                  w_en_sel;
    logic                  w_dp_sel;
    logic                  w_sup_sel;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an;
    logic [6:0]            w_rom_seg;

    // ------------------------------------------------------------------
    // Scan sequencing: ON for CLK_DIV cycles, optional BLANK, then advance.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt + 1'b1;
        w_adv      = 1'b0;
        if (r_state == c_ST_ON) begin
            if (r_cnt == c_ON_LAST) begin
                w_cnt_nx = '0;
                if (BLANK_CLKS > 0) begin
                    w_state_nx = c_ST_BLANK;
                end else begin
                    w_adv = 1'b1;
                end
            end
        end else if (r_cnt == c_BLANK_LAST) begin
            w_cnt_nx   = '0;
            w_state_nx = c_ST_ON;
            w_adv      = 1'b1;
        end
        if (w_adv) begin
            w_idx_nx = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    assign w_wrap = w_adv && (r_idx == c_IDX_LAST);

    // frame_done is registered one cycle ahead so that it sits on the wrap
    // cycle itself; a load seen together with frame_done takes the bypass.
    always_comb begin
        if (BLANK_CLKS > 0) begin
            w_nx_is_wrap = (w_idx_nx == c_IDX_LAST) && (w_state_nx == c_ST_BLANK)
                           && (w_cnt_nx == c_BLANK_LAST);
        end else begin
            w_nx_is_wrap = (w_idx_nx == c_IDX_LAST) && (w_state_nx == c_ST_ON)
                           && (w_cnt_nx == c_ON_LAST);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= c_ST_ON;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_fd    <= w_nx_is_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Double buffering: the active set only changes on the wrap cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_wrap && load) begin
            r_act_val    <= value_in;
            r_act_dp     <= dp_in;
            r_act_en     <= digit_en_in;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_wrap && r_pend_valid) begin
                r_act_val    <= r_pend_val;
                r_act_dp     <= r_pend_dp;
                r_act_en     <= r_pend_en;
                r_pend_valid <= 1'b0;
            end
            if (load) begin
                r_pend_val   <= value_in;
                r_pend_dp    <= dp_in;
                r_pend_en    <= digit_en_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression: walk down from the most significant digit
    // while every nibble seen so far is zero. Digit 0 is never suppressed.
    // ------------------------------------------------------------------
    always_comb begin
        w_zero_run = 1'b1;
        w_sup      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (r_act_val[4*i +: 4] == 4'h0);
            w_sup[i]   = lz_en && w_zero_run;
        end
    end

    // Per-slot selection of the current digit's data and anode
    always_comb begin
        w_nib     = '0;
        w_en_sel  = 1'b0;
        w_dp_sel  = 1'b0;
        w_sup_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib     = r_act_val[4*i +: 4];
                w_en_sel  = r_act_en[i];
                w_dp_sel  = r_act_dp[i];
                w_sup_sel = w_sup[i];
            end
        end
    end

    assign w_lit = (r_state == c_ST_ON) && w_en_sel && !w_sup_sel;

    always_comb begin
        w_an = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_an[i] = w_lit;
            end
        end
    end

    seg7_hex_rom u_hex_rom (
        .i_nibble (w_nib),
        .o_seg    (w_rom_seg)
    );

    // ------------------------------------------------------------------
    // Output registers: polarity is applied only here.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_seg <= c_SEG_OFF;
            r_dp  <= c_DP_OFF;
            r_an  <= c_AN_OFF;
        end else begin
            r_seg <= (w_lit ? w_rom_seg : 7'h00) ^ c_SEG_OFF;
            r_dp  <= (w_lit && w_dp_sel) ^ c_DP_OFF;
            r_an  <= w_an ^ c_AN_OFF;
        end
    end

    assign seg_o      = r_seg;
    assign dp_o       = r_dp;
    assign an_o       = r_an;
    assign digit_idx  = r_idx;
    assign frame_done = r_fd;

endmodule

`default_nettype wire
